// File: rtl/mc_control_fsm_pkg.sv
// Shared multicycle-CPU definitions: state codes, opcodes and datapath select encodings.
package mc_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_IMM_EXEC = 4'd11,
        S_IMM_WB   = 4'd12,
        S_ERROR    = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // States that stall on mem_ready and are guarded by the timeout counter.
    function automatic logic is_wait(state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_control_fsm_timer.sv
// Memory wait-cycle counter: cleared on clr, counts while inc, saturates at all-ones.
module mem_wait_timer #(
    parameter int TO_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    output logic [TO_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle CPU control FSM with single-step support, memory timeout and sticky error flags.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 8,
    parameter int ENABLE_IMM  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       step_mode,
    input  logic       step,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_write_ne,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       mem_err,
    output logic       illegal_op
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

    state_t          cur_state, nxt_state;
    logic [TO_W-1:0] wait_cnt;
    logic            timeout, set_mem_err, set_illegal;

    // Any state change restarts the count, so each wait state starts from zero.
    mem_wait_timer #(.TO_W(TO_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (nxt_state != cur_state),
        .inc   (is_wait(cur_state) && !mem_ready),
        .count (wait_cnt)
    );

    assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt == TO_LIMIT) && !mem_ready;
    assign state   = cur_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state  <= S_IDLE;
            mem_err    <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            if (set_mem_err) mem_err    <= 1'b1;
            if (set_illegal) illegal_op <= 1'b1;
        end
    end

    always_comb begin
        nxt_state     = cur_state;
        set_mem_err   = 1'b0;
        set_illegal   = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_write_ne   = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_src        = PC_ALU;
        instr_done    = 1'b0;
        // Retire target follows step_mode as sampled at the retire cycle.
        case (cur_state)
            S_IDLE: if (!step_mode || step) nxt_state = S_FETCH;
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    nxt_state = S_DECODE;
                end else if (timeout) begin
                    nxt_state   = S_ERROR;
                    set_mem_err = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = SRCB_BOFS;
                case (opcode)
                    OP_RTYPE:      nxt_state = S_R_EXEC;
                    OP_LW, OP_SW:  nxt_state = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: nxt_state = S_BRANCH;
                    OP_J:          nxt_state = S_JUMP;
                    OP_ADDI: begin
                        if (ENABLE_IMM != 0) begin
                            nxt_state = S_IMM_EXEC;
                        end else begin
                            nxt_state   = S_ERROR;
                            set_illegal = 1'b1;
                        end
                    end
                    default: begin
                        nxt_state   = S_ERROR;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                nxt_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    nxt_state = S_MEM_WB;
                end else if (timeout) begin
                    nxt_state   = S_ERROR;
                    set_mem_err = 1'b1;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                nxt_state  = step_mode ? S_IDLE : S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    nxt_state  = step_mode ? S_IDLE : S_FETCH;
                end else if (timeout) begin
                    nxt_state   = S_ERROR;
                    set_mem_err = 1'b1;
                end
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                nxt_state = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                nxt_state  = step_mode ? S_IDLE : S_FETCH;
            end
            S_IMM_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                nxt_state = S_IMM_WB;
            end
            S_IMM_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                nxt_state  = step_mode ? S_IDLE : S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_src        = PC_ALUOUT;
                pc_write_cond = (opcode == OP_BEQ);
                pc_write_ne   = (opcode == OP_BNE);
                instr_done    = 1'b1;
                nxt_state     = step_mode ? S_IDLE : S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_src     = PC_JUMP;
                instr_done = 1'b1;
                nxt_state  = step_mode ? S_IDLE : S_FETCH;
            end
            S_ERROR: nxt_state = S_ERROR;
            default: nxt_state = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: stimulus queues expected per-cycle outputs, a monitor compares.
module tb_mc_control_fsm;

    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MADDR = 4'd3,
                           S_MRD = 4'd4, S_MWB = 4'd5, S_MWR = 4'd6, S_REX = 4'd7,
                           S_RWB = 4'd8, S_BR = 4'd9, S_JMP = 4'd10, S_ERR = 4'd13;

    logic       clk = 1'b0, rst = 1'b1, mem_ready = 1'b1, step_mode = 1'b0, step = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       pc_write, pc_write_cond, pc_write_ne, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, mem_err, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    mc_control_fsm #(.MEM_TIMEOUT(4), .TO_W(8), .ENABLE_IMM(0)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .step_mode(step_mode), .step(step),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_write_ne(pc_write_ne),
        .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .state(state), .instr_done(instr_done), .mem_err(mem_err), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic       pc_write, pc_write_cond, pc_write_ne, iord, mem_read, mem_write, ir_write;
        logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
        logic [1:0] alu_src_b, alu_op, pc_src;
        logic       instr_done, mem_err, illegal_op;
        logic [3:0] state;
    } obs_t;

    typedef struct {
        int    c;
        string name;
        obs_t  mask;
        obs_t  val;
    } exp_t;

    exp_t exp_q[$];
    int   ret_q[$];
    int   n_checks = 0, n_fail = 0;

    function automatic obs_t mk(logic [3:0] s);
        obs_t v = '0;
        v.state = s;
        return v;
    endfunction

    task automatic expect_full(int c, string name, obs_t v);
        exp_t e;
        e.c = c; e.name = name; e.mask = '1; e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic expect_state(int c, string name, logic [3:0] s);
        exp_t e;
        e.c = c; e.name = name; e.mask = '0; e.mask.state = 4'hf; e.val = mk(s);
        exp_q.push_back(e);
    endtask

    // Monitor: compare every expectation due this cycle, and every instr_done pulse.
    always @(negedge clk) begin
        obs_t o;
        o = {pc_write, pc_write_cond, pc_write_ne, iord, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
             instr_done, mem_err, illegal_op, state};
        for (int i = 0; i < exp_q.size(); ) begin
            if (exp_q[i].c == cyc) begin
                n_checks++;
                if ((o & exp_q[i].mask) !== (exp_q[i].val & exp_q[i].mask)) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got=%h want=%h mask=%h", exp_q[i].name, cyc,
                             o, exp_q[i].val, exp_q[i].mask);
                end
                exp_q.delete(i);
            end else if (exp_q[i].c < cyc) begin
                n_checks++; n_fail++;
                $display("FAIL %s not sampled at cyc=%0d", exp_q[i].name, exp_q[i].c);
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
        if (instr_done !== 1'b0) begin
            n_checks++;
            if (ret_q.size() == 0) begin
                n_fail++;
                $display("FAIL retire unexpected instr_done=%b at cyc=%0d", instr_done, cyc);
            end else begin
                int r;
                r = ret_q.pop_front();
                if (r != cyc) begin
                    n_fail++;
                    $display("FAIL retire cyc got=%0d want=%0d", cyc, r);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) tick();
    endtask

    // Leaves the DUT in IDLE during the cycle before the returned first-FETCH cycle.
    task automatic do_reset(output int f);
        rst = 1'b1;
        tick();
        expect_full(cyc, "reset_outputs", mk(S_IDLE));
        tick();
        rst = 1'b0;
        f = cyc + 1;
    endtask

    function automatic obs_t fetch_obs(logic rdy);
        obs_t v = mk(S_FETCH);
        v.mem_read = 1'b1; v.alu_src_b = 2'b01;
        v.pc_write = rdy;  v.ir_write  = rdy;
        return v;
    endfunction

    initial begin
        int   f, c0;
        obs_t v;

        // lw, free run, zero wait
        opcode = 6'b100011; mem_ready = 1'b1; step_mode = 1'b0;
        do_reset(f);
        expect_full(f, "lw_fetch", fetch_obs(1'b1));
        v = mk(S_DECODE); v.alu_src_b = 2'b11; expect_full(f + 1, "lw_decode", v);
        v = mk(S_MADDR); v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; expect_full(f + 2, "lw_maddr", v);
        v = mk(S_MRD); v.mem_read = 1'b1; v.iord = 1'b1; expect_full(f + 3, "lw_memrd", v);
        v = mk(S_MWB); v.reg_write = 1'b1; v.mem_to_reg = 1'b1; v.instr_done = 1'b1;
        expect_full(f + 4, "lw_memwb", v);
        ret_q.push_back(f + 4);
        expect_state(f + 5, "lw_refetch", S_FETCH);
        wait_cyc(f + 5);

        // sw with three wait cycles in MEM_WR
        opcode = 6'b101011;
        do_reset(f);
        expect_state(f + 2, "sw_maddr", S_MADDR);
        wait_cyc(f + 3);
        mem_ready = 1'b0;
        v = mk(S_MWR); v.mem_write = 1'b1; v.iord = 1'b1;
        for (int k = 0; k < 3; k++) expect_full(f + 3 + k, "sw_wait", v);
        v.instr_done = 1'b1; expect_full(f + 6, "sw_done", v);
        ret_q.push_back(f + 6);
        expect_full(f + 7, "sw_refetch", fetch_obs(1'b1));
        wait_cyc(f + 6);
        mem_ready = 1'b1;
        wait_cyc(f + 7);

        // lw: mem_ready arrives in the cycle the timeout would fire
        opcode = 6'b100011;
        do_reset(f);
        wait_cyc(f + 3);
        mem_ready = 1'b0;
        v = mk(S_MRD); v.mem_read = 1'b1; v.iord = 1'b1;
        expect_full(f + 7, "lw_late_ready", v);
        v = mk(S_MWB); v.reg_write = 1'b1; v.mem_to_reg = 1'b1; v.instr_done = 1'b1;
        expect_full(f + 8, "lw_late_wb", v);
        ret_q.push_back(f + 8);
        wait_cyc(f + 7);
        mem_ready = 1'b1;
        wait_cyc(f + 8);

        // mem_ready stuck low in FETCH -> timeout
        mem_ready = 1'b0;
        do_reset(f);
        expect_full(f, "to_fetch_first", fetch_obs(1'b0));
        expect_full(f + 4, "to_fetch_last", fetch_obs(1'b0));
        v = mk(S_ERR); v.mem_err = 1'b1;
        expect_full(f + 5, "to_error", v);
        expect_full(f + 8, "to_error_hold", v);
        wait_cyc(f + 6);
        mem_ready = 1'b1;
        wait_cyc(f + 8);

        // addi with immediates disabled -> illegal
        opcode = 6'b001000;
        do_reset(f);
        v = mk(S_DECODE); v.alu_src_b = 2'b11; expect_full(f + 1, "addi_decode", v);
        v = mk(S_ERR); v.illegal_op = 1'b1;
        expect_full(f + 2, "addi_illegal", v);
        expect_full(f + 4, "addi_illegal_hold", v);
        wait_cyc(f + 4);

        // single-step beq
        step_mode = 1'b1; opcode = 6'b000100;
        do_reset(f);
        c0 = cyc;
        expect_full(c0 + 2, "step_idle_wait", mk(S_IDLE));
        wait_cyc(c0 + 3);
        f = c0 + 4;
        expect_state(f, "step_fetch", S_FETCH);
        expect_state(f + 1, "step_decode", S_DECODE);
        v = mk(S_BR); v.alu_src_a = 1'b1; v.alu_op = 2'b01; v.pc_src = 2'b01;
        v.pc_write_cond = 1'b1; v.instr_done = 1'b1;
        expect_full(f + 2, "beq_branch", v);
        ret_q.push_back(f + 2);
        expect_full(f + 3, "step_back_idle", mk(S_IDLE));
        expect_full(f + 5, "step_idle_hold", mk(S_IDLE));
        step = 1'b1; tick(); step = 1'b0;
        wait_cyc(f + 1);
        step = 1'b1; tick(); step = 1'b0;
        wait_cyc(f + 5);

        // rst while MEM_RD is waiting
        step_mode = 1'b0; opcode = 6'b100011;
        do_reset(f);
        wait_cyc(f + 3);
        mem_ready = 1'b0;
        expect_state(f + 5, "rdwait_memrd", S_MRD);
        wait_cyc(f + 5);
        rst = 1'b1;
        tick();
        expect_full(cyc, "rst_mid_wait", mk(S_IDLE));
        mem_ready = 1'b1;

        // free-run R-type, j, bne; step_mode raised mid-bne takes effect at retire
        opcode = 6'b000000;
        do_reset(f);
        v = mk(S_REX); v.alu_src_a = 1'b1; v.alu_op = 2'b10; expect_full(f + 2, "r_exec", v);
        v = mk(S_RWB); v.reg_write = 1'b1; v.reg_dst = 1'b1; v.instr_done = 1'b1;
        expect_full(f + 3, "r_wb", v);
        ret_q.push_back(f + 3);
        wait_cyc(f + 4);
        opcode = 6'b000010;
        v = mk(S_JMP); v.pc_write = 1'b1; v.pc_src = 2'b10; v.instr_done = 1'b1;
        expect_full(f + 6, "j_jump", v);
        ret_q.push_back(f + 6);
        wait_cyc(f + 7);
        opcode = 6'b000101;
        v = mk(S_BR); v.alu_src_a = 1'b1; v.alu_op = 2'b01; v.pc_src = 2'b01;
        v.pc_write_ne = 1'b1; v.instr_done = 1'b1;
        expect_full(f + 9, "bne_branch", v);
        ret_q.push_back(f + 9);
        expect_full(f + 10, "bne_step_idle", mk(S_IDLE));
        wait_cyc(f + 8);
        step_mode = 1'b1;
        wait_cyc(f + 12);

        foreach (exp_q[i]) begin
            n_checks++; n_fail++;
            $display("FAIL %s never sampled (cyc %0d)", exp_q[i].name, exp_q[i].c);
        end
        foreach (ret_q[i]) begin
            n_checks++; n_fail++;
            $display("FAIL retire missing got=none want=cyc %0d", ret_q[i]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 16, giving the wait cycles allowed for mem_ready; 0 disables the timeout.
REQ-003 The block SHALL have parameter TO_W, default 8, giving the timeout counter width.
REQ-004 The block SHALL have parameter ENABLE_IMM, default 1; when 1, addi (001000) is legal.
REQ-005 The block SHALL have ports, one per line, name direction width meaning:
clk  in  1  clock
rst  in  1  synchronous active-high reset
opcode  in  6  IR[31:26], valid from DECODE onward
mem_ready  in  1  memory completes current access this cycle
step_mode  in  1  1 = single-step, 0 = free run
step  in  1  one-cycle debounced pulse, single-step advance
pc_write, pc_write_cond, pc_write_ne  out  1 each  PC enables: unconditional, on zero, on non-zero
iord, mem_read, mem_write, ir_write  out  1 each  memory/IR controls
mem_to_reg, reg_dst, reg_write, alu_src_a  out  1 each  datapath selects/enables
alu_src_b, alu_op, pc_src  out  2 each  mux selects and ALU class
state  out  4  current state code, for display
instr_done  out  1  one-cycle pulse when an instruction retires
mem_err  out  1  sticky memory-timeout flag
illegal_op  out  1  sticky illegal-opcode flag

Function
REQ-006 The block SHALL use states IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, BRANCH, JUMP, IMM_EXEC, IMM_WB and ERROR.
REQ-007 From IDLE, the block SHALL enter FETCH when step_mode=0, or when step_mode=1 and step=1; otherwise it SHALL stay in IDLE.
REQ-008 In FETCH, the block SHALL drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01 and alu_op=00; on mem_ready=1 it SHALL also drive ir_write=1 and pc_write=1 with pc_src=00, then go to DECODE.
REQ-009 In DECODE, the block SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=00.
REQ-010 DECODE SHALL dispatch as follows: 000000 to R_EXEC; 100011 and 101011 to MEM_ADDR; 000100 and 000101 to BRANCH; 000010 to JUMP; 001000 to IMM_EXEC when ENABLE_IMM=1; any other opcode to ERROR with illegal_op set.
REQ-011 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=00, then go to MEM_RD for lw or MEM_WR for sw.
REQ-012 MEM_RD SHALL drive mem_read=1 and iord=1 and hold until mem_ready=1, then go to MEM_WB.
REQ-013 MEM_WB SHALL drive reg_write=1, mem_to_reg=1 and reg_dst=0.
REQ-014 MEM_WR SHALL drive mem_write=1 and iord=1 and hold until mem_ready=1.
REQ-015 R_EXEC SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=10; R_WB SHALL drive reg_write=1, reg_dst=1 and mem_to_reg=0.
REQ-016 IMM_EXEC SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=00; IMM_WB SHALL drive reg_write=1, reg_dst=0 and mem_to_reg=0.
REQ-017 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01 and pc_src=01, with pc_write_cond=1 for beq or pc_write_ne=1 for bne.
REQ-018 JUMP SHALL drive pc_write=1 and pc_src=10.
REQ-019 Any output not listed for a state SHALL be 0.
REQ-020 All outputs SHALL be decoded from registered state (plus mem_ready in FETCH, MEM_RD and MEM_WR) only.
REQ-021 The retire states are MEM_WB, MEM_WR on mem_ready, R_WB, IMM_WB, BRANCH and JUMP; each SHALL pulse instr_done=1 and go to FETCH when step_mode=0, or to IDLE when step_mode=1.
REQ-022 With zero memory wait, latencies from FETCH entry to the instr_done cycle SHALL be: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3 cycles.
REQ-023 A timeout counter SHALL clear on entry to each wait state and increment every cycle that mem_ready=0 in FETCH, MEM_RD or MEM_WR.
REQ-024 When the timeout counter equals MEM_TIMEOUT (MEM_TIMEOUT≠0) with mem_ready=0, the block SHALL go to ERROR and set mem_err.
REQ-025 If mem_ready=1 in the same cycle that the timeout would fire, the access SHALL complete normally.
REQ-026 ERROR SHALL drive all controls to 0 and SHALL be left only by rst; mem_err and illegal_op SHALL hold until rst.
REQ-027 A step pulse outside IDLE SHALL be ignored.
REQ-028 A change of step_mode SHALL take effect at the next retire.

Reset
REQ-029 On rst, the block SHALL go to IDLE on the next edge, clear both flags and the timeout counter, and drive all outputs to 0 (state=IDLE code 0), including when rst arrives mid-instruction or mid-wait.

Structure
REQ-030 State encodings, opcode constants, alu_op codes and alu_src_b/pc_src select codes SHALL live in the shared CPU package.
REQ-031 The timeout counter SHALL be one sub-module, mem_wait_timer.

Verification
REQ-032 Bench: step_mode=0, mem_ready always 1, opcode 100011 -> states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB with instr_done in cycle 5.
REQ-033 Bench: sw with mem_ready low for 3 cycles in MEM_WR -> mem_write held for 4 cycles, instr_done on the 4th, mem_err=0.
REQ-034 Bench: MEM_TIMEOUT=4, mem_ready stuck at 0 in FETCH -> ERROR after 4 wait cycles, mem_err=1, outputs 0 until rst.
REQ-035 Bench: opcode 001000 with ENABLE_IMM=0 -> ERROR after DECODE, illegal_op=1.
REQ-036 Bench: step_mode=1, beq -> IDLE until step, instr_done after 3 cycles with pc_write_cond=1, then back to IDLE.
REQ-037 Bench: rst during MEM_RD wait -> IDLE next cycle, all outputs 0.
